// File: rtl/encode_rp_pkg.sv
// Shared constants, FSM encoding and radix helper for the NTRU Prime Encode engine.
package encode_rp_pkg;

    localparam int R_W         = 14;
    localparam int EMIT_THRESH = 16384;

    // sntrup761 parameter set: Rq uses q, Rounded uses (q+2)/3
    localparam int NTRU_P       = 761;
    localparam int NTRU_Q       = 4591;
    localparam int NTRU_ROUNDED = 1531;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LVL_INIT,
        ST_RD_A,
        ST_RD_B,
        ST_MUL,
        ST_EMIT,
        ST_WB,
        ST_TAIL,
        ST_TAIL_WB,
        ST_FIN_LD,
        ST_FINAL,
        ST_DONE
    } enc_state_e;

    // Radix left after one byte has been peeled off: ceil(m / 256)
    function automatic logic [15:0] shrink_radix(input logic [15:0] m);
        logic [16:0] t;
        t = ({1'b0, m} + 17'd255) >> 8;
        return 16'(t);
    endfunction

endpackage

// File: rtl/encode_rp_if.sv
// Control, work-RAM and output-RAM signals of the Encode engine.
interface encode_rp_if
    import encode_rp_pkg::*;
#(
    parameter int DEPTH     = 10,
    parameter int OUT_DEPTH = 11,
    parameter int R_WIDTH   = R_W
) ();
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [OUT_DEPTH-1:0] out_len;
    logic [DEPTH-1:0]     wk_rd_addr;
    logic [R_WIDTH-1:0]   wk_rd_data;
    logic                 wk_wr_en;
    logic [DEPTH-1:0]     wk_wr_addr;
    logic [R_WIDTH-1:0]   wk_wr_data;
    logic                 out_we;
    logic [OUT_DEPTH-1:0] out_addr;
    logic [7:0]           out_data;

    modport slave (
        input  start, wk_rd_data,
        output busy, done, out_len, wk_rd_addr, wk_wr_en, wk_wr_addr, wk_wr_data,
               out_we, out_addr, out_data
    );

    modport master (
        output start, wk_rd_data,
        input  busy, done, out_len, wk_rd_addr, wk_wr_en, wk_wr_addr, wk_wr_data,
               out_we, out_addr, out_data
    );
endinterface

// File: rtl/encode_rp_reduce.sv
// Combinational byte peel-off for one pair: up to two bytes until the radix drops below 16384.
module encode_reduce
    import encode_rp_pkg::*;
#(
    parameter int R_WIDTH = R_W
) (
    input  logic [2*R_WIDTH-1:0] r_i,
    input  logic [2*R_WIDTH-1:0] mm_i,
    output logic [7:0]           byte0_o,
    output logic [7:0]           byte1_o,
    output logic [1:0]           cnt_o,
    output logic [R_WIDTH-1:0]   r_o,
    output logic [R_WIDTH-1:0]   mm_o
);
    localparam int PW = 2 * R_WIDTH;
    localparam logic [PW:0] K255 = (PW+1)'(255);
    localparam logic [PW:0] THR  = (PW+1)'(EMIT_THRESH);

    // one spare bit so the +255 rounding cannot wrap
    logic [PW:0] mm0;
    logic [PW:0] mm1;
    logic [PW:0] mm2;

    always_comb begin
        mm0     = {1'b0, mm_i};
        mm1     = (mm0 + K255) >> 8;
        mm2     = (mm1 + K255) >> 8;
        byte0_o = r_i[7:0];
        byte1_o = r_i[15:8];
        if (mm0 < THR) begin
            cnt_o = 2'd0;
            r_o   = R_WIDTH'(r_i);
            mm_o  = R_WIDTH'(mm0);
        end else if (mm1 < THR) begin
            cnt_o = 2'd1;
            r_o   = R_WIDTH'(r_i >> 8);
            mm_o  = R_WIDTH'(mm1);
        end else begin
            cnt_o = 2'd2;
            r_o   = R_WIDTH'(r_i >> 16);
            mm_o  = R_WIDTH'(mm2);
        end
    end
endmodule

// File: rtl/encode_rp.sv
// NTRU Prime mixed-radix Encode: folds pairs level by level in the work RAM, streaming bytes out.
module encode_rp
    import encode_rp_pkg::*;
#(
    parameter int P_LEN     = NTRU_P,
    parameter int M0        = NTRU_Q,
    parameter int R_WIDTH   = R_W,
    parameter int DEPTH     = 10,
    parameter int OUT_DEPTH = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    encode_rp_if.slave bus
);
    localparam int PW = 2 * R_WIDTH;

    enc_state_e           state_q, state_d;
    logic [DEPTH:0]       n_q, n_d;
    logic [DEPTH-1:0]     i_q, i_d;
    logic [R_WIDTH-1:0]   m_q, m_d, m_last_q, m_last_d, m_new_q, m_new_d, a_q, a_d;
    logic [PW-1:0]        mm_q, mm_d, mml_q, mml_d, pmm_q, pmm_d, r_q, r_d;
    logic                 e_q, e_d;
    logic [OUT_DEPTH-1:0] out_addr_q, out_addr_d, out_len_q, out_len_d;

    logic [DEPTH-1:0]     half;
    logic                 last_pair;
    logic                 out_we_c;
    logic [7:0]           red_b0, red_b1;
    logic [1:0]           red_cnt;
    logic [R_WIDTH-1:0]   red_r, red_mm;

    assign half      = n_q[DEPTH:1];
    assign last_pair = !n_q[0] && (i_q == half - DEPTH'(1));

    encode_reduce #(.R_WIDTH(R_WIDTH)) u_reduce (
        .r_i     (r_q),
        .mm_i    (pmm_q),
        .byte0_o (red_b0),
        .byte1_o (red_b1),
        .cnt_o   (red_cnt),
        .r_o     (red_r),
        .mm_o    (red_mm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            i_q        <= '0;
            m_q        <= '0;
            m_last_q   <= '0;
            m_new_q    <= '0;
            a_q        <= '0;
            mm_q       <= '0;
            mml_q      <= '0;
            pmm_q      <= '0;
            r_q        <= '0;
            e_q        <= 1'b0;
            out_addr_q <= '0;
            out_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            i_q        <= i_d;
            m_q        <= m_d;
            m_last_q   <= m_last_d;
            m_new_q    <= m_new_d;
            a_q        <= a_d;
            mm_q       <= mm_d;
            mml_q      <= mml_d;
            pmm_q      <= pmm_d;
            r_q        <= r_d;
            e_q        <= e_d;
            out_addr_q <= out_addr_d;
            out_len_q  <= out_len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        i_d        = i_q;
        m_d        = m_q;
        m_last_d   = m_last_q;
        m_new_d    = m_new_q;
        a_d        = a_q;
        mm_d       = mm_q;
        mml_d      = mml_q;
        pmm_d      = pmm_q;
        r_d        = r_q;
        e_d        = e_q;
        out_addr_d = out_we_c ? out_addr_q + OUT_DEPTH'(1) : out_addr_q;
        out_len_d  = out_len_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d    = ST_LVL_INIT;
                n_d        = (DEPTH+1)'(P_LEN);
                m_d        = R_WIDTH'(M0);
                m_last_d   = R_WIDTH'(M0);
                out_addr_d = '0;
            end
            ST_LVL_INIT: begin
                i_d     = '0;
                mm_d    = PW'(m_q) * PW'(m_q);
                mml_d   = PW'(m_q) * PW'(m_last_q);
                state_d = (n_q == (DEPTH+1)'(1)) ? ST_FIN_LD : ST_RD_A;
            end
            ST_RD_A: state_d = ST_RD_B;
            ST_RD_B: begin
                a_d     = bus.wk_rd_data;
                state_d = ST_MUL;
            end
            // The multiplier is always the lower element's radix, which is m; only the
            // pair radix differs on the last pair of an even level.
            ST_MUL: begin
                r_d     = PW'(a_q) + PW'(m_q) * PW'(bus.wk_rd_data);
                pmm_d   = last_pair ? mml_q : mm_q;
                e_d     = 1'b0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (!e_q && red_cnt == 2'd2) e_d = 1'b1;
                else                         state_d = ST_WB;
            end
            ST_WB: begin
                if (last_pair) m_last_d = red_mm;
                else           m_new_d  = red_mm;
                if (i_q + DEPTH'(1) < half) begin
                    i_d     = i_q + DEPTH'(1);
                    state_d = ST_RD_A;
                end else if (n_q[0]) begin
                    state_d = ST_TAIL;
                end else begin
                    n_d     = n_q - (DEPTH+1)'(half);
                    m_d     = m_new_q;
                    state_d = ST_LVL_INIT;
                end
            end
            ST_TAIL: state_d = ST_TAIL_WB;
            ST_TAIL_WB: begin
                n_d     = n_q - (DEPTH+1)'(half);
                m_d     = m_new_q;
                state_d = ST_LVL_INIT;
            end
            ST_FIN_LD: begin
                r_d     = PW'(bus.wk_rd_data);
                state_d = ST_FINAL;
            end
            ST_FINAL: begin
                if (m_last_q > R_WIDTH'(1)) begin
                    r_d      = r_q >> 8;
                    m_last_d = R_WIDTH'(shrink_radix(16'(m_last_q)));
                end else begin
                    out_len_d = out_addr_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        bus.done       = (state_q == ST_DONE);
        bus.wk_rd_addr = '0;
        bus.wk_wr_en   = 1'b0;
        bus.wk_wr_addr = '0;
        bus.wk_wr_data = '0;
        out_we_c       = 1'b0;
        bus.out_data   = '0;
        case (state_q)
            ST_RD_A: bus.wk_rd_addr = DEPTH'({i_q, 1'b0});
            ST_RD_B: bus.wk_rd_addr = DEPTH'({i_q, 1'b1});
            ST_EMIT: begin
                out_we_c     = red_cnt > {1'b0, e_q};
                bus.out_data = e_q ? red_b1 : red_b0;
            end
            ST_WB: begin
                bus.wk_wr_en   = 1'b1;
                bus.wk_wr_addr = i_q;
                bus.wk_wr_data = red_r;
            end
            ST_TAIL: bus.wk_rd_addr = DEPTH'(n_q - (DEPTH+1)'(1));
            ST_TAIL_WB: begin
                bus.wk_wr_en   = 1'b1;
                bus.wk_wr_addr = half;
                bus.wk_wr_data = bus.wk_rd_data;
            end
            ST_FINAL: begin
                out_we_c     = m_last_q > R_WIDTH'(1);
                bus.out_data = r_q[7:0];
            end
            default: ;
        endcase
        bus.out_we = out_we_c;
    end

    assign bus.out_addr = out_addr_q;
    assign bus.out_len  = out_len_q;

endmodule

// File: tb/tb_encode_rp.sv
// Bench for encode_rp: several parameter sets, each checked byte by byte against a list-based Encode model.
module tb_encode_rp;
    localparam int NCFG = 5;
    localparam int CFG_P [NCFG] = '{1, 2, 3, 761, 761};
    localparam int CFG_M [NCFG] = '{4591, 256, 4591, 4591, 1531};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NCFG-1:0] rst_n_v, start_v, ld_en_v;
    logic [NCFG-1:0] busy_v, done_v, we_v;
    logic [9:0]      ld_addr;
    logic [13:0]     ld_data;
    logic [10:0]     oaddr_w [NCFG];
    logic [10:0]     olen_w  [NCFG];
    logic [7:0]      odata_w [NCFG];

    int total = 0;
    int bad   = 0;

    int       rin    [1024];
    logic [7:0] expb [2048];
    int       exp_n;
    longint   mdl_r  [1024];
    longint   mdl_m  [1024];

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        encode_rp_if #(.DEPTH(10), .OUT_DEPTH(11), .R_WIDTH(14)) bus ();
        logic [13:0] wk_mem [1024];
        logic [13:0] rd_q;

        encode_rp #(
            .P_LEN(CFG_P[gi]), .M0(CFG_M[gi]), .R_WIDTH(14), .DEPTH(10), .OUT_DEPTH(11)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n_v[gi]),
            .bus   (bus)
        );

        always @(posedge clk) begin
            rd_q <= wk_mem[bus.wk_rd_addr];
            if (ld_en_v[gi])       wk_mem[ld_addr]        <= ld_data;
            else if (bus.wk_wr_en) wk_mem[bus.wk_wr_addr] <= bus.wk_wr_data;
        end

        assign bus.start      = start_v[gi];
        assign bus.wk_rd_data = rd_q;
        assign busy_v[gi]     = bus.busy;
        assign done_v[gi]     = bus.done;
        assign we_v[gi]       = bus.out_we;
        assign oaddr_w[gi]    = bus.out_addr;
        assign odata_w[gi]    = bus.out_data;
        assign olen_w[gi]     = bus.out_len;
    end

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference Encode on explicit value/radix lists, one level per outer iteration
    task automatic model(input int k);
        int len, nl;
        longint r, mm;
        len = CFG_P[k];
        for (int j = 0; j < len; j++) begin
            mdl_r[j] = rin[j];
            mdl_m[j] = CFG_M[k];
        end
        exp_n = 0;
        while (len > 1) begin
            nl = 0;
            for (int j = 0; j + 1 < len; j += 2) begin
                r  = mdl_r[j] + mdl_m[j] * mdl_r[j+1];
                mm = mdl_m[j] * mdl_m[j+1];
                while (mm >= 16384) begin
                    expb[exp_n] = 8'(r % 256);
                    exp_n++;
                    r  = r / 256;
                    mm = (mm + 255) / 256;
                end
                mdl_r[nl] = r;
                mdl_m[nl] = mm;
                nl++;
            end
            if (len % 2 == 1) begin
                mdl_r[nl] = mdl_r[len-1];
                mdl_m[nl] = mdl_m[len-1];
                nl++;
            end
            len = nl;
        end
        r  = mdl_r[0];
        mm = mdl_m[0];
        while (mm > 1) begin
            expb[exp_n] = 8'(r % 256);
            exp_n++;
            r  = r / 256;
            mm = (mm + 255) / 256;
        end
    endtask

    task automatic load(input int k);
        for (int a = 0; a < CFG_P[k]; a++) begin
            @(negedge clk);
            ld_addr    = 10'(a);
            ld_data    = 14'(rin[a]);
            ld_en_v[k] = 1'b1;
        end
        @(negedge clk);
        ld_en_v[k] = 1'b0;
    endtask

    // Starts instance k and checks every written byte; abort_at >= 0 pulses reset at that cycle
    task automatic run(input int k, input int abort_at);
        int seen;
        bit fin;
        bit got_done;
        load(k);
        model(k);
        @(negedge clk) start_v[k] = 1'b1;
        @(negedge clk) start_v[k] = 1'b0;
        check($sformatf("cfg%0d busy_after_start", k), busy_v[k], 1);
        seen = 0;
        fin = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 30000 && !fin; c++) begin
            if (we_v[k]) begin
                check($sformatf("cfg%0d byte%0d addr", k, seen), oaddr_w[k], seen);
                check($sformatf("cfg%0d byte%0d data", k, seen), odata_w[k],
                      (seen < exp_n) ? int'(expb[seen]) : -1);
                seen++;
            end
            if (done_v[k]) begin
                check($sformatf("cfg%0d busy_in_done", k), busy_v[k], 0);
                check($sformatf("cfg%0d out_len", k), olen_w[k], exp_n);
                check($sformatf("cfg%0d byte_count", k), seen, exp_n);
                fin = 1'b1;
                got_done = 1'b1;
            end else if (c == abort_at) begin
                rst_n_v[k] = 1'b0;
                @(negedge clk);
                check($sformatf("cfg%0d rst busy", k), busy_v[k], 0);
                check($sformatf("cfg%0d rst done", k), done_v[k], 0);
                check($sformatf("cfg%0d rst out_we", k), we_v[k], 0);
                check($sformatf("cfg%0d rst out_addr", k), oaddr_w[k], 0);
                check($sformatf("cfg%0d rst out_len", k), olen_w[k], 0);
                rst_n_v[k] = 1'b1;
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check($sformatf("cfg%0d done_timeout", k), 0, 1);
        if (got_done) begin
            start_v[k] = 1'b1;
            @(negedge clk);
            start_v[k] = 1'b0;
            check($sformatf("cfg%0d done_one_cycle", k), done_v[k], 0);
            check($sformatf("cfg%0d start_in_done_ignored", k), busy_v[k], 0);
            @(negedge clk);
            check($sformatf("cfg%0d still_idle", k), busy_v[k], 0);
        end
    endtask

    initial begin
        rst_n_v = '0;
        start_v = '0;
        ld_en_v = '0;
        ld_addr = '0;
        ld_data = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("cfg%0d reset busy", k), busy_v[k], 0);
            check($sformatf("cfg%0d reset done", k), done_v[k], 0);
            check($sformatf("cfg%0d reset out_we", k), we_v[k], 0);
            check($sformatf("cfg%0d reset out_len", k), olen_w[k], 0);
            check($sformatf("cfg%0d reset out_addr", k), oaddr_w[k], 0);
        end
        rst_n_v = '1;
        @(negedge clk);

        rin[0] = 1000;
        run(0, -1);
        check("pin cfg0 count", exp_n, 2);
        check("pin cfg0 b0", expb[0], 8'hE8);
        check("pin cfg0 b1", expb[1], 8'h03);
        run(0, -1);

        rin[0] = 'h12;
        rin[1] = 'h34;
        run(1, -1);
        check("pin cfg1 count", exp_n, 2);
        check("pin cfg1 b0", expb[0], 8'h12);
        check("pin cfg1 b1", expb[1], 8'h34);

        for (int j = 0; j < 3; j++) rin[j] = 4590;
        run(2, -1);
        check("pin cfg2 count", exp_n, 5);
        check("pin cfg2 b0", expb[0], 8'h20);
        check("pin cfg2 b1", expb[1], 8'h9D);
        check("pin cfg2 b2", expb[2], 8'h9D);
        check("pin cfg2 b3", expb[3], 8'h8E);
        check("pin cfg2 b4", expb[4], 8'h16);

        for (int j = 0; j < 761; j++) rin[j] = int'($urandom_range(0, 4590));
        run(3, 300);
        @(negedge clk);
        run(3, -1);
        check("pin cfg3 count", exp_n, 1158);
        check("cfg3 out_len literal", olen_w[3], 1158);

        for (int j = 0; j < 761; j++) rin[j] = int'($urandom_range(0, 1530));
        run(4, -1);
        check("pin cfg4 count", exp_n, 1007);
        check("cfg4 out_len literal", olen_w[4], 1007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
